afifo_rd_ctrl: RTL and testbench

Read-side controller of the async FIFO, clocked in the read domain. It takes the 2-flop-synchronized gray write pointer, keeps the read pointer in binary and gray, and issues reads to the dual-port RAM (1-cycle synchronous read latency). It presents first-word-fall-through data through a 2-entry output buffer with a valid/ready handshake. It also returns the registered gray read pointer to the write-domain synchronizer and reports empty, almost-empty and fill level.

---
 rtl/afifo_rd_ctrl.sv | 153 +++++++++++++++
 tb/tb_afifo_rd_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_ctrl.sv
// Read-side controller of the async FIFO (read clock domain).
// Tracks the read pointer in binary and gray, issues reads to a dual-port RAM
// with one cycle of read latency, and presents first-word-fall-through data
// through a two-entry output buffer with a valid/ready handshake.
module afifo_rd_ctrl #(
    parameter int PTR_WIDTH  = 5,
    parameter int DATA_WIDTH = 8,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                  rd_clk_i,
    input  logic                  rst_i,
    input  logic [PTR_WIDTH:0]    wp2rp_gray_i,
    output logic [PTR_WIDTH:0]    rptr_gray_o,
    output logic                  ram_rd_en_o,
    output logic [PTR_WIDTH-1:0]  ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic                  empty_o,
    output logic                  aempty_o,
    output logic [PTR_WIDTH:0]    rd_level_o
);

    localparam int PW = PTR_WIDTH + 1;

    // Occupancy encoding doubles as the word count held in the buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t            state_reg, state_next;
    logic [PW-1:0]         rbin_reg;
    logic [PW-1:0]         rgray_reg;
    logic                  infl_reg;
    logic [DATA_WIDTH-1:0] head_reg, head_next;
    logic [DATA_WIDTH-1:0] tail_reg, tail_next;
    logic [PW-1:0]         level_reg;
    logic                  aempty_reg;

    logic [PW-1:0]         wbin;
    logic [PW-1:0]         rbin_inc;
    logic [PW-1:0]         ram_level;
    logic [PW-1:0]         level_next;
    logic [1:0]            occ;
    logic [2:0]            committed;
    logic                  ram_empty;
    logic                  pop;
    logic                  capture;
    logic                  issue;

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wbin[gi] = ^wp2rp_gray_i[PW-1:gi];
        end
    endgenerate

    assign occ        = state_reg;
    assign rd_valid_o = (state_reg != BUF_EMPTY);
    assign pop        = rd_valid_o & rd_ready_i;
    assign capture    = infl_reg;

    // rgray_reg always holds bin2gray(rbin_reg), so it serves the empty compare.
    assign ram_empty  = (rgray_reg == wp2rp_gray_i);
    assign ram_level  = wbin - rbin_reg;
    assign rbin_inc   = rbin_reg + PW'(1);

    // Issue only while the words already committed to the buffer leave a free slot.
    assign committed  = 3'(occ) + 3'(infl_reg) - 3'(pop);
    assign issue      = ~rst_i & ~ram_empty & (committed < 3'd2);

    // Level after this edge; an issue only moves a word from RAM to in-flight.
    assign level_next = ram_level + PW'(occ) + PW'(infl_reg) - PW'(pop);

    assign ram_rd_en_o   = issue;
    assign ram_rd_addr_o = rbin_reg[PTR_WIDTH-1:0];
    assign rptr_gray_o   = rgray_reg;
    assign rd_data_o     = head_reg;
    assign empty_o       = ~rd_valid_o;
    assign rd_level_o    = level_reg;
    assign aempty_o      = aempty_reg;

    // Output buffer next state: head is always the oldest word, tail the next.
    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        case (state_reg)
            BUF_EMPTY: begin
                if (capture) begin
                    head_next  = ram_rd_data_i;
                    state_next = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (capture && !pop) begin
                    tail_next  = ram_rd_data_i;
                    state_next = BUF_TWO;
                end else if (capture && pop) begin
                    head_next  = ram_rd_data_i;
                end else if (pop) begin
                    state_next = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_next = tail_reg;
                    if (capture) begin
                        tail_next = ram_rd_data_i;
                    end else begin
                        state_next = BUF_ONE;
                    end
                end
            end
            default: begin
                state_next = BUF_EMPTY;
            end
        endcase
    end

    // Pointer, in-flight, buffer and level registers.
    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            rbin_reg   <= '0;
            rgray_reg  <= '0;
            infl_reg   <= 1'b0;
            state_reg  <= BUF_EMPTY;
            head_reg   <= '0;
            tail_reg   <= '0;
            level_reg  <= '0;
            aempty_reg <= 1'b1;
        end else begin
            if (issue) begin
                rbin_reg  <= rbin_inc;
                rgray_reg <= rbin_inc ^ (rbin_inc >> 1);
            end
            infl_reg   <= issue;
            state_reg  <= state_next;
            head_reg   <= head_next;
            tail_reg   <= tail_next;
            level_reg  <= level_next;
            aempty_reg <= (level_next <= PW'(AEMPTY_TH));
        end
    end

    // A capture into a full buffer would drop a word; the issue rule must prevent it.
    a_no_overflow: assert property (@(posedge rd_clk_i) disable iff (rst_i)
        !(capture && state_reg == BUF_TWO));

endmodule

// File: tb/tb_afifo_rd_ctrl.sv
// Directed bench for the async FIFO read-side controller with a behavioural
// one-cycle-latency RAM whose contents equal their address unless overridden.
module tb_afifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [5:0] wp2rp_gray_i;
    logic [5:0] rptr_gray_o;
    logic       ram_rd_en_o;
    logic [4:0] ram_rd_addr_o;
    logic [7:0] ram_rd_data_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       rd_ready_i;
    logic       empty_o;
    logic       aempty_o;
    logic [5:0] rd_level_o;

    logic [7:0] mem [0:31];
    int checks = 0;
    int errors = 0;

    afifo_rd_ctrl #(.PTR_WIDTH(5), .DATA_WIDTH(8), .AEMPTY_TH(4)) dut (
        .rd_clk_i      (clk),
        .rst_i         (rst_i),
        .wp2rp_gray_i  (wp2rp_gray_i),
        .rptr_gray_o   (rptr_gray_o),
        .ram_rd_en_o   (ram_rd_en_o),
        .ram_rd_addr_o (ram_rd_addr_o),
        .ram_rd_data_i (ram_rd_data_i),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .empty_o       (empty_o),
        .aempty_o      (aempty_o),
        .rd_level_o    (rd_level_o)
    );

    always #5 clk = ~clk;

    // RAM model: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; wp2rp_gray_i = '0; rd_ready_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; wp2rp_gray_i = 6'b000101; rd_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rptr_gray_o !== 6'd0) begin errors++; $display("FAIL reset_rptr cyc %0d got %b want 000000", c, rptr_gray_o); end
            checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d got %b want 0", c, rd_valid_o); end
            checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty cyc %0d got %b want 1", c, empty_o); end
            checks++; if (aempty_o !== 1'b1) begin errors++; $display("FAIL reset_aempty cyc %0d got %b want 1", c, aempty_o); end
            checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en cyc %0d got %b want 0", c, ram_rd_en_o); end
            checks++; if (rd_level_o !== 6'd0) begin errors++; $display("FAIL reset_level cyc %0d got %0d want 0", c, rd_level_o); end
            checks++; if (rd_data_o !== 8'd0) begin errors++; $display("FAIL reset_data cyc %0d got %h want 00", c, rd_data_o); end
        end
        $display("reset: held 3 cycles, outputs idle");
    endtask

    task automatic test_single();
        do_reset();
        mem[0] = 8'hA5;
        rd_ready_i = 1'b1; wp2rp_gray_i = 6'b000001;
        @(negedge clk); // cycle t
        checks++; if (ram_rd_en_o !== 1'b1) begin errors++; $display("FAIL single_en_t got %b want 1", ram_rd_en_o); end
        checks++; if (ram_rd_addr_o !== 5'd0) begin errors++; $display("FAIL single_addr_t got %0d want 0", ram_rd_addr_o); end
        @(negedge clk); // t+1
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_t1 got %b want 0", rd_valid_o); end
        checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL single_en_t1 got %b want 0", ram_rd_en_o); end
        checks++; if (rd_level_o !== 6'd1) begin errors++; $display("FAIL single_level_t1 got %0d want 1", rd_level_o); end
        @(negedge clk); // t+2
        checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid_t2 got %b want 1", rd_valid_o); end
        checks++; if (rd_data_o !== 8'hA5) begin errors++; $display("FAIL single_data_t2 got %h want a5", rd_data_o); end
        checks++; if (rptr_gray_o !== 6'b000001) begin errors++; $display("FAIL single_rptr got %b want 000001", rptr_gray_o); end
        checks++; if (rd_level_o !== 6'd1) begin errors++; $display("FAIL single_level_t2 got %0d want 1", rd_level_o); end
        @(negedge clk); // t+3
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_t3 got %b want 0", rd_valid_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL single_empty_t3 got %b want 1", empty_o); end
        checks++; if (rd_level_o !== 6'd0) begin errors++; $display("FAIL single_level_t3 got %0d want 0", rd_level_o); end
        checks++; if (aempty_o !== 1'b1) begin errors++; $display("FAIL single_aempty_t3 got %b want 1", aempty_o); end
        @(posedge clk); #1;
        mem[0] = 8'd0;
        $display("single: one word a5 delivered");
    endtask

    task automatic test_stream();
        int got;
        do_reset();
        got = 0;
        rd_ready_i = 1'b1; wp2rp_gray_i = 6'b110000;
        for (int cyc = 0; cyc < 60 && got < 32; cyc++) begin
            @(negedge clk);
            if (rd_valid_o) begin
                checks++; if (rd_data_o !== 8'(got)) begin errors++; $display("FAIL stream_data word %0d got %0d want %0d", got, rd_data_o, got); end
                checks++; if (cyc !== 2 + got) begin errors++; $display("FAIL stream_timing word %0d got cycle %0d want %0d", got, cyc, 2 + got); end
                got++;
            end
        end
        checks++; if (got !== 32) begin errors++; $display("FAIL stream_count got %0d want 32", got); end
        @(negedge clk);
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL stream_valid_end got %b want 0", rd_valid_o); end
        checks++; if (rptr_gray_o !== 6'b110000) begin errors++; $display("FAIL stream_rptr got %b want 110000", rptr_gray_o); end
        checks++; if (rd_level_o !== 6'd0) begin errors++; $display("FAIL stream_level got %0d want 0", rd_level_o); end
        @(posedge clk); #1;
        $display("stream: %0d words", got);
    endtask

    task automatic test_backpressure();
        int issues;
        int got;
        do_reset();
        issues = 0; got = 0;
        rd_ready_i = 1'b0; wp2rp_gray_i = 6'b001111; // binary 10
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ram_rd_en_o) issues++;
            if (c >= 2) begin
                checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'd0) begin errors++; $display("FAIL bp_hold cyc %0d got valid %b data %0d want 1 0", c, rd_valid_o, rd_data_o); end
            end
        end
        checks++; if (issues !== 2) begin errors++; $display("FAIL bp_issues got %0d want 2", issues); end
        checks++; if (rd_level_o !== 6'd10) begin errors++; $display("FAIL bp_level got %0d want 10", rd_level_o); end
        checks++; if (aempty_o !== 1'b0) begin errors++; $display("FAIL bp_aempty got %b want 0", aempty_o); end
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            rd_ready_i = (cyc % 2 == 0);
            @(negedge clk);
            if (ram_rd_en_o) issues++;
            if (rd_valid_o) begin
                checks++; if (rd_data_o !== 8'(got)) begin errors++; $display("FAIL bp_order cyc %0d got %0d want %0d", cyc, rd_data_o, got); end
                if (rd_ready_i) got++;
            end
            @(posedge clk); #1;
        end
        rd_ready_i = 1'b1;
        checks++; if (got !== 10) begin errors++; $display("FAIL bp_count got %0d want 10", got); end
        checks++; if (issues !== 10) begin errors++; $display("FAIL bp_total_issues got %0d want 10", issues); end
        @(negedge clk);
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_end got %b want 0", rd_valid_o); end
        checks++; if (rd_level_o !== 6'd0) begin errors++; $display("FAIL bp_level_end got %0d want 0", rd_level_o); end
        @(posedge clk); #1;
        $display("backpressure: %0d words, %0d reads", got, issues);
    endtask

    task automatic test_wrap();
        int got;
        int n_addr;
        int k;
        int exp_val [6] = '{30, 31, 0, 1, 2, 3};
        logic exp_ae;
        do_reset();
        got = 0; n_addr = 0; k = 0;
        rd_ready_i = 1'b1; wp2rp_gray_i = 6'b010001; // binary 30
        for (int cyc = 0; cyc < 80 && got < 30; cyc++) begin
            @(negedge clk);
            if (rd_valid_o) got++;
        end
        checks++; if (got !== 30) begin errors++; $display("FAIL wrap_preload got %0d want 30", got); end
        @(posedge clk); #1;
        rd_ready_i = 1'b0; wp2rp_gray_i = 6'b110110; // binary 36
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ram_rd_en_o && n_addr < 6) begin
                checks++; if (ram_rd_addr_o !== 5'(exp_val[n_addr])) begin errors++; $display("FAIL wrap_addr %0d got %0d want %0d", n_addr, ram_rd_addr_o, exp_val[n_addr]); end
                n_addr++;
            end
        end
        checks++; if (rd_level_o !== 6'd6) begin errors++; $display("FAIL wrap_level_full got %0d want 6", rd_level_o); end
        checks++; if (aempty_o !== 1'b0) begin errors++; $display("FAIL wrap_aempty_full got %b want 0", aempty_o); end
        @(posedge clk); #1;
        rd_ready_i = 1'b1;
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            @(negedge clk);
            if (ram_rd_en_o && n_addr < 6) begin
                checks++; if (ram_rd_addr_o !== 5'(exp_val[n_addr])) begin errors++; $display("FAIL wrap_addr %0d got %0d want %0d", n_addr, ram_rd_addr_o, exp_val[n_addr]); end
                n_addr++;
            end
            if (rd_valid_o) begin
                exp_ae = ((6 - k) <= 4);
                checks++; if (rd_data_o !== 8'(exp_val[k])) begin errors++; $display("FAIL wrap_data %0d got %0d want %0d", k, rd_data_o, exp_val[k]); end
                checks++; if (rd_level_o !== 6'(6 - k)) begin errors++; $display("FAIL wrap_level %0d got %0d want %0d", k, rd_level_o, 6 - k); end
                checks++; if (aempty_o !== exp_ae) begin errors++; $display("FAIL wrap_aempty %0d got %b want %b", k, aempty_o, exp_ae); end
                k++;
            end
        end
        checks++; if (k !== 6 || n_addr !== 6) begin errors++; $display("FAIL wrap_count got words %0d reads %0d want 6 6", k, n_addr); end
        @(negedge clk);
        checks++; if (rd_level_o !== 6'd0 || aempty_o !== 1'b1) begin errors++; $display("FAIL wrap_end got level %0d aempty %b want 0 1", rd_level_o, aempty_o); end
        checks++; if (rptr_gray_o !== 6'b110110) begin errors++; $display("FAIL wrap_rptr got %b want 110110", rptr_gray_o); end
        @(posedge clk); #1;
        $display("wrap: %0d words across pointer wrap", k);
    endtask

    task automatic test_midreset();
        do_reset();
        rd_ready_i = 1'b0; wp2rp_gray_i = 6'b001111;
        @(negedge clk);
        checks++; if (ram_rd_en_o !== 1'b1) begin errors++; $display("FAIL mid_en0 got %b want 1", ram_rd_en_o); end
        @(negedge clk);
        checks++; if (ram_rd_en_o !== 1'b1) begin errors++; $display("FAIL mid_en1 got %b want 1", ram_rd_en_o); end
        @(posedge clk); #1;
        rst_i = 1'b1; wp2rp_gray_i = '0;
        @(negedge clk);
        checks++; if (ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL mid_en_rst got %b want 0", ram_rd_en_o); end
        @(posedge clk); #1;
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rd_valid_o !== 1'b0 || ram_rd_en_o !== 1'b0) begin errors++; $display("FAIL mid_idle cyc %0d got valid %b en %b want 0 0", c, rd_valid_o, ram_rd_en_o); end
            checks++; if (rptr_gray_o !== 6'd0 || rd_level_o !== 6'd0) begin errors++; $display("FAIL mid_ptr cyc %0d got rptr %b level %0d want 0 0", c, rptr_gray_o, rd_level_o); end
        end
        @(posedge clk); #1;
        wp2rp_gray_i = 6'b000011; // binary 2
        @(negedge clk);
        checks++; if (ram_rd_en_o !== 1'b1 || ram_rd_addr_o !== 5'd0) begin errors++; $display("FAIL mid_restart got en %b addr %0d want 1 0", ram_rd_en_o, ram_rd_addr_o); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== 8'd0) begin errors++; $display("FAIL mid_first got valid %b data %0d want 1 0", rd_valid_o, rd_data_o); end
        @(posedge clk); #1;
        $display("midreset: buffered words discarded, restart from 0");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        ram_rd_data_i = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
